karlsen_ladder_mc: RTL and testbench

Multi-channel, time-multiplexed 4-pole Karlsen fast ladder low-pass filter with run-time cutoff, resonance feedback and LP2/LP4 tap select. One shared multiplier and an FSM iterate over all channels once per rising edge of sample_clk. Sits between the codec sample interface and per-channel cores. Replaces the fixed-gain single-channel ladder.

---
 rtl/karlsen_pkg.sv | 41 ++++
 rtl/karlsen_ladder_mc_mac.sv | 38 +++
 rtl/karlsen_ladder_mc.sv | 179 +++++++++++++++++
 tb/tb_karlsen_ladder_mc.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/karlsen_pkg.sv
// Shared types and helpers for the multi-channel Karlsen ladder.
//   state_t       : sequencer states, one multiply per state
//   RES_INT_BITS  : integer bits of the resonance word (Q2.x)
//   sat_acc/out   : signed clamp to a given width (never wraps)
package karlsen_pkg;

  typedef enum logic [2:0] {IDLE, FB, S1, S2, S3, S4, ST, DONE} state_t;

  localparam int RES_INT_BITS = 2;

  // Wide enough for any product/sum used in the datapath.
  localparam int SAT_IN_W = 48;
  localparam logic signed [SAT_IN_W-1:0] SAT_ONE = 1;

  function automatic logic signed [SAT_IN_W-1:0] sat_s(
    input logic signed [SAT_IN_W-1:0] v,
    input int                          w
  );
    logic signed [SAT_IN_W-1:0] mx, mn;
    mx = (SAT_ONE <<< (w - 1)) - SAT_ONE;
    mn = -mx - SAT_ONE;
    if (v > mx)      return mx;
    else if (v < mn) return mn;
    return v;
  endfunction

  function automatic logic signed [SAT_IN_W-1:0] sat_acc(
    input logic signed [SAT_IN_W-1:0] v,
    input int                          acc_w
  );
    return sat_s(v, acc_w);
  endfunction

  function automatic logic signed [SAT_IN_W-1:0] sat_out(
    input logic signed [SAT_IN_W-1:0] v,
    input int                          w
  );
    return sat_s(v, w);
  endfunction

endpackage

// File: rtl/karlsen_ladder_mc_mac.sv
// Shared multiply-shift-accumulate for the ladder (combinational; the
// caller registers the result).
//   fb_op = 0 : result = sat(base + ((diff * coef) >>> SH_A))   ladder stage
//   fb_op = 1 : result = sat(base - ((diff * coef) >>> SH_B))   feedback sub
// Ports: base (ACC_W signed), diff (ACC_W+1 signed), coef (K_W unsigned),
//        fb_op, result (ACC_W signed).
module ladder_mac
  import karlsen_pkg::*;
#(
  parameter int ACC_W = 18,
  parameter int K_W   = 16,
  parameter int SH_A  = 16,
  parameter int SH_B  = 14
) (
  input  logic signed [ACC_W-1:0] base,
  input  logic signed [ACC_W:0]   diff,
  input  logic        [K_W-1:0]   coef,
  input  logic                    fb_op,
  output logic signed [ACC_W-1:0] result
);

  localparam int PW = ACC_W + 1 + K_W + 1;

  logic signed [PW-1:0]       diff_x, coef_x, prod, scaled;
  logic signed [SAT_IN_W-1:0] scaled_x, sum;

  always_comb begin
    diff_x   = PW'(diff);
    coef_x   = PW'($signed({1'b0, coef}));
    prod     = diff_x * coef_x;
    // >>> on a signed product floors toward -inf
    scaled   = fb_op ? (prod >>> SH_B) : (prod >>> SH_A);
    scaled_x = SAT_IN_W'(scaled);
    sum      = SAT_IN_W'(base) + (fb_op ? -scaled_x : scaled_x);
    result   = ACC_W'(sat_acc(sum, ACC_W));
  end

endmodule

// File: rtl/karlsen_ladder_mc.sv
// Time-multiplexed 4-pole Karlsen ladder LPF, CHANNELS channels sharing one
// multiplier. Each sample_clk rising edge runs one pass over all channels
// (FB, S1..S4, ST per channel), then publishes every output at once.
// Ports:
//   clk, rst        system clock, async active-high reset
//   sample_clk      sample strobe level (sync to clk); rising edge = start
//   in              packed signed samples, channel c at [c*W +: W]
//   g, resonance    cutoff (Q0.G_W) and feedback gain (Q2.RES_W-2), shared
//   mode            0 = LP4 tap, 1 = LP2 tap
//   out             packed signed outputs, updated atomically
//   out_valid       1-clk pulse when out updates
//   busy            pass in progress
//   overrun         1-clk pulse on a start seen while not idle
module karlsen_ladder_mc
  import karlsen_pkg::*;
#(
  parameter int W        = 16,
  parameter int CHANNELS = 4,
  parameter int G_W      = 16,
  parameter int RES_W    = 16,
  parameter int ACC_W    = W + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_clk,
  input  logic [CHANNELS*W-1:0] in,
  input  logic [G_W-1:0]        g,
  input  logic [RES_W-1:0]      resonance,
  input  logic                  mode,
  output logic [CHANNELS*W-1:0] out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int RES_FRAC = RES_W - RES_INT_BITS;
  localparam int K_W      = (G_W > RES_W) ? G_W : RES_W;
  localparam int D_W      = ACC_W + 1;
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_t state, state_nxt;

  // sample_clk is registered once before edge detection; start then lines
  // up with the edge that first captured the strobe high.
  logic sample_clk_q, sample_clk_d, start;
  assign start = sample_clk_q & ~sample_clk_d;

  logic [CH_W-1:0]              ch;
  logic [CHANNELS-1:0][W-1:0]   in_sh, out_sh;
  logic [G_W-1:0]               g_sh;
  logic [RES_W-1:0]             res_sh;
  logic                         mode_sh;

  logic signed [ACC_W-1:0]      stg [CHANNELS][4];
  logic signed [ACC_W-1:0]      x_q;

  logic                         last_ch;
  logic [1:0]                   idx;
  logic signed [ACC_W-1:0]      cur, src, tap;
  logic signed [ACC_W-1:0]      mac_base, mac_res;
  logic signed [D_W-1:0]        mac_diff;
  logic [K_W-1:0]               mac_coef;
  logic                         mac_fb;
  logic [W-1:0]                 tap_sat;

  assign last_ch = (ch == CH_W'(CHANNELS - 1));

  // Operand mux for the one shared MAC.
  always_comb begin
    idx = 2'd0;
    case (state)
      S2:      idx = 2'd1;
      S3:      idx = 2'd2;
      S4:      idx = 2'd3;
      default: idx = 2'd0;
    endcase
    cur = stg[ch][idx];
    // S1 follows the feedback node; later poles follow the pole just
    // updated earlier in this same pass.
    src = (state == S1) ? x_q : stg[ch][idx - 2'd1];

    mac_base = cur;
    mac_diff = D_W'(src) - D_W'(cur);
    mac_coef = K_W'(g_sh);
    mac_fb   = 1'b0;
    if (state == FB) begin
      mac_base = ACC_W'($signed(in_sh[ch]));
      mac_diff = D_W'(stg[ch][3]);
      mac_coef = K_W'(res_sh);
      mac_fb   = 1'b1;
    end

    tap     = mode_sh ? stg[ch][1] : stg[ch][3];
    tap_sat = W'(sat_out(SAT_IN_W'(tap), W));
  end

  ladder_mac #(
    .ACC_W (ACC_W),
    .K_W   (K_W),
    .SH_A  (G_W),
    .SH_B  (RES_FRAC)
  ) u_mac (
    .base   (mac_base),
    .diff   (mac_diff),
    .coef   (mac_coef),
    .fb_op  (mac_fb),
    .result (mac_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FB;
      FB:      state_nxt = S1;
      S1:      state_nxt = S2;
      S2:      state_nxt = S3;
      S3:      state_nxt = S4;
      S4:      state_nxt = ST;
      ST:      state_nxt = last_ch ? DONE : FB;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_clk_q <= 1'b0;
      sample_clk_d <= 1'b0;
      ch           <= '0;
      in_sh        <= '0;
      out_sh       <= '0;
      g_sh         <= '0;
      res_sh       <= '0;
      mode_sh      <= 1'b0;
      x_q          <= '0;
      out          <= '0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k < 4; k++)
          stg[c][k] <= '0;
    end else begin
      sample_clk_q <= sample_clk;
      sample_clk_d <= sample_clk_q;
      out_valid    <= 1'b0;
      // A start anywhere outside IDLE (DONE included) is dropped.
      overrun      <= start && (state != IDLE);
      case (state)
        IDLE: if (start) begin
          in_sh   <= in;
          g_sh    <= g;
          res_sh  <= resonance;
          mode_sh <= mode;
          ch      <= '0;
          busy    <= 1'b1;
        end
        FB:             x_q          <= mac_res;
        S1, S2, S3, S4: stg[ch][idx] <= mac_res;
        ST: begin
          out_sh[ch] <= tap_sat;
          if (!last_ch) ch <= ch + CH_W'(1);
        end
        DONE: begin
          out       <= out_sh;
          out_valid <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_karlsen_ladder_mc.sv
module tb_karlsen_ladder_mc;

  localparam int W = 16, CH = 4, G_W = 16, RES_W = 16, ACC_W = W + 2;
  localparam int LAT = 6 * CH + 2;

  logic              clk = 1'b0;
  logic              rst, sample_clk, mode;
  logic [CH*W-1:0]   in_bus, out;
  logic [G_W-1:0]    g;
  logic [RES_W-1:0]  resonance;
  logic              out_valid, busy, overrun;

  always #5 clk = ~clk;

  karlsen_ladder_mc #(.W(W), .CHANNELS(CH), .G_W(G_W), .RES_W(RES_W)) dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk), .in(in_bus), .g(g),
    .resonance(resonance), .mode(mode), .out(out), .out_valid(out_valid),
    .busy(busy), .overrun(overrun)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (plain integer arithmetic) ----------
  longint m_a [CH][4];
  longint m_out [CH];

  function automatic longint clampv(input longint v, input int w);
    longint mx, mn;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -mx - 1;
    return (v > mx) ? mx : ((v < mn) ? mn : v);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_out[c] = 0;
      for (int k = 0; k < 4; k++) m_a[c][k] = 0;
    end
  endtask

  // One pass using whatever inputs are currently driven.
  task automatic model_pass();
    longint xin, fb, x, src, gl, rl;
    gl = longint'(g);
    rl = longint'(resonance);
    for (int c = 0; c < CH; c++) begin
      xin = longint'($signed(in_bus[c*W +: W]));
      fb  = (m_a[c][3] * rl) >>> (RES_W - 2);
      x   = clampv(xin - fb, ACC_W);
      for (int k = 0; k < 4; k++) begin
        src = (k == 0) ? x : m_a[c][k-1];
        m_a[c][k] = clampv(m_a[c][k] + (((src - m_a[c][k]) * gl) >>> G_W), ACC_W);
      end
      m_out[c] = clampv(mode ? m_a[c][1] : m_a[c][3], W);
    end
  endtask

  function automatic longint out_ch(input int c);
    return longint'($signed(out[c*W +: W]));
  endfunction

  task automatic check_outs(input string tag);
    for (int c = 0; c < CH; c++)
      chk($sformatf("%s ch%0d", tag, c), out_ch(c), m_out[c]);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
  endtask

  // Raise sample_clk, optionally a second edge / input scramble mid-pass,
  // and wait (bounded) for out_valid. lat = clk edges after start edge.
  task automatic run_pass(input int edge2, input int scramble,
                          output int lat, output int ovr);
    lat = -1; ovr = 0;
    @(negedge clk); sample_clk = 1'b1;
    for (int n = 1; n <= 100 && lat < 0; n++) begin
      @(posedge clk); @(negedge clk);
      if (overrun)   ovr++;
      if (out_valid) lat = n - 1;
      if (n == 2) sample_clk = 1'b0;
      if (edge2 > 0 && n == edge2)     sample_clk = 1'b1;
      if (edge2 > 0 && n == edge2 + 2) sample_clk = 1'b0;
      if (scramble > 0 && n == scramble) begin
        in_bus = {$urandom, $urandom};
        g = G_W'($urandom); resonance = RES_W'($urandom); mode = ~mode;
      end
    end
  endtask

  task automatic set_in(input int v0, input int v1, input int v2, input int v3);
    in_bus[0*W +: W] = W'(v0); in_bus[1*W +: W] = W'(v1);
    in_bus[2*W +: W] = W'(v2); in_bus[3*W +: W] = W'(v3);
  endtask

  typedef struct {
    int in_v [CH];
    int g, res, mode;
    int exp  [CH];
  } vec_t;
  vec_t tbl [8];

  initial begin
    int lat, ovr, cnt_v, cnt_o;
    rst = 1'b1; sample_clk = 1'b0; in_bus = '0; g = '0; resonance = '0; mode = 1'b0;
    model_reset();

    tbl[0].in_v = '{16384, 0, 0, 0};      tbl[0].g = 32768; tbl[0].res = 0;     tbl[0].mode = 0; tbl[0].exp = '{1024, 0, 0, 0};
    tbl[1].in_v = '{0, 0, -16384, 0};     tbl[1].g = 32768; tbl[1].res = 0;     tbl[1].mode = 0; tbl[1].exp = '{0, 0, -1024, 0};
    tbl[2].in_v = '{0, 0, -16384, 0};     tbl[2].g = 32768; tbl[2].res = 0;     tbl[2].mode = 1; tbl[2].exp = '{0, 0, -4096, 0};
    tbl[3].in_v = '{20000, 20000, 20000, 20000}; tbl[3].g = 0; tbl[3].res = 0;  tbl[3].mode = 0; tbl[3].exp = '{0, 0, 0, 0};
    tbl[4].in_v = '{0, 16384, 0, 0};      tbl[4].g = 65535; tbl[4].res = 0;     tbl[4].mode = 0; tbl[4].exp = '{0, 16380, 0, 0};
    tbl[5].in_v = '{-1, 0, 0, 0};         tbl[5].g = 32768; tbl[5].res = 0;     tbl[5].mode = 0; tbl[5].exp = '{-1, 0, 0, 0};
    tbl[6].in_v = '{0, 0, 0, 8000};       tbl[6].g = 65535; tbl[6].res = 65535; tbl[6].mode = 1; tbl[6].exp = '{0, 0, 0, 7998};
    tbl[7].in_v = '{0, 0, 0, -32768};     tbl[7].g = 65535; tbl[7].res = 0;     tbl[7].mode = 0; tbl[7].exp = '{0, 0, 0, -32768};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst out", longint'(out), 0);
    chk("rst out_valid", longint'(out_valid), 0);
    chk("rst busy", longint'(busy), 0);
    chk("rst overrun", longint'(overrun), 0);
    rst = 1'b0;

    // Table vectors, each from a clean state
    for (int i = 0; i < 8; i++) begin
      do_reset();
      set_in(tbl[i].in_v[0], tbl[i].in_v[1], tbl[i].in_v[2], tbl[i].in_v[3]);
      g = G_W'(tbl[i].g); resonance = RES_W'(tbl[i].res); mode = tbl[i].mode[0];
      run_pass(0, 0, lat, ovr);
      chk($sformatf("vec%0d latency", i), lat, LAT);
      for (int c = 0; c < CH; c++)
        chk($sformatf("vec%0d ch%0d", i, c), out_ch(c), longint'(tbl[i].exp[c]));
    end

    // DC step settles near the input
    do_reset();
    set_in(16384, 0, 0, 0); g = 16'd32768; resonance = '0; mode = 1'b0;
    for (int p = 0; p < 60; p++) begin
      model_pass();
      run_pass(0, 0, lat, ovr);
      if (p == 0) chk("dc first latency", lat, LAT);
    end
    check_outs("dc60");
    chk("dc60 within 4", longint'((out_ch(0) >= 16380 && out_ch(0) <= 16388) ? 1 : 0), 1);

    // g = 0 holds zero state
    do_reset();
    set_in(20000, 20000, 20000, 20000); g = '0; resonance = 16'd30000;
    for (int p = 0; p < 10; p++) begin
      run_pass(0, 0, lat, ovr);
      for (int c = 0; c < CH; c++)
        chk($sformatf("g0 p%0d ch%0d", p, c), out_ch(c), 0);
    end

    // Saturation with heavy feedback
    do_reset();
    set_in(32767, 0, 0, 0); g = 16'hFFFF; resonance = 16'hFFFF; mode = 1'b0;
    for (int p = 0; p < 200; p++) begin
      model_pass();
      run_pass(0, 0, lat, ovr);
      chk($sformatf("sat p%0d ch0", p), out_ch(0), m_out[0]);
    end

    // Overrun: second edge 10 cycles in, inputs scrambled mid-pass
    in_bus = {$urandom, $urandom}; g = G_W'($urandom); resonance = RES_W'($urandom);
    model_pass();
    run_pass(10, 5, lat, ovr);
    chk("ovr latency", lat, LAT);
    chk("ovr pulses", ovr, 1);
    check_outs("ovr values");
    cnt_v = 0; cnt_o = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) cnt_v++;
      if (overrun)   cnt_o++;
    end
    chk("ovr no extra pass", cnt_v, 0);
    chk("ovr no extra pulse", cnt_o, 0);
    chk("ovr idle busy", longint'(busy), 0);
    check_outs("ovr hold");

    // Reset mid-pass
    @(negedge clk); sample_clk = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == 2) sample_clk = 1'b0;
    end
    chk("mid busy before rst", longint'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid rst out", longint'(out), 0);
    chk("mid rst busy", longint'(busy), 0);
    chk("mid rst out_valid", longint'(out_valid), 0);
    chk("mid rst overrun", longint'(overrun), 0);
    @(negedge clk); rst = 1'b0;
    model_reset();

    // Random passes, state carried across passes
    for (int p = 0; p < 30; p++) begin
      in_bus = {$urandom, $urandom};
      g = G_W'($urandom); resonance = RES_W'($urandom); mode = $urandom_range(0, 1) == 1;
      model_pass();
      run_pass(0, 0, lat, ovr);
      chk($sformatf("rnd p%0d latency", p), lat, LAT);
      check_outs($sformatf("rnd p%0d", p));
      g = G_W'($urandom); in_bus = {$urandom, $urandom}; mode = ~mode;
      repeat (5) @(negedge clk);
      check_outs($sformatf("rnd p%0d hold", p));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
